// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter that times how long the memory strobes stay up.
// A load always restarts from MEM_LAT-1, so the zero flag marks the last strobe cycle.
module dmem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] count;

  // Reload on a new grant, otherwise count down while the access is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MEM_LAT - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the DMA/debug port.
// Each granted access holds the strobes for MEM_LAT cycles, then spends one RESP cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t state, state_next;
  owner_t     owner, last_owner;

  logic grant_cpu;
  logic grant_dma;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic finish;

  dmem_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_counter (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration (ties go to whoever did not win last) and counter control.
  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i && (!dma_req_i || (last_owner == OWN_DMA))) begin
          grant_cpu  = 1'b1;
          cnt_load   = 1'b1;
          state_next = BUSY;
        end else if (dma_req_i) begin
          grant_dma  = 1'b1;
          cnt_load   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          finish     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winner's access into the memory strobes, capture read data at the end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner        <= OWN_CPU;
      last_owner   <= OWN_DMA;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_rdata_o  <= '0;
      dma_rdata_o  <= '0;
      dma_gnt_o    <= 1'b0;
      dma_rvalid_o <= 1'b0;
    end else begin
      dma_gnt_o    <= grant_dma;
      dma_rvalid_o <= finish && (owner == OWN_DMA);
      if (grant_cpu) begin
        mem_read_o  <= ~cpu_we_i;
        mem_write_o <= cpu_we_i;
        mem_addr_o  <= cpu_addr_i;
        mem_wdata_o <= cpu_wdata_i;
        owner       <= OWN_CPU;
        last_owner  <= OWN_CPU;
      end else if (grant_dma) begin
        mem_read_o  <= ~dma_we_i;
        mem_write_o <= dma_we_i;
        mem_addr_o  <= dma_addr_i;
        mem_wdata_o <= dma_wdata_i;
        owner       <= OWN_DMA;
        last_owner  <= OWN_DMA;
      end
      if (finish) begin
        mem_read_o  <= 1'b0;
        mem_write_o <= 1'b0;
        if (mem_read_o) begin
          if (owner == OWN_CPU) begin
            cpu_rdata_o <= mem_rdata_i;
          end else begin
            dma_rdata_o <= mem_rdata_i;
          end
        end
      end
    end
  end

  assign cpu_stall_o = cpu_req_i & ~((state == RESP) && (owner == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with MEM_LAT = 2.
module tb_dmem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dma_req_i;
  logic        dma_we_i;
  logic [31:0] dma_addr_i;
  logic [31:0] dma_wdata_i;
  logic        dma_gnt_o;
  logic        dma_rvalid_o;
  logic [31:0] dma_rdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .dma_req_i   (dma_req_i),
    .dma_we_i    (dma_we_i),
    .dma_addr_i  (dma_addr_i),
    .dma_wdata_i (dma_wdata_i),
    .dma_gnt_o   (dma_gnt_o),
    .dma_rvalid_o(dma_rvalid_o),
    .dma_rdata_o (dma_rdata_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic [31:0] md);
    cpu_req_i   = cr;
    cpu_we_i    = cw;
    cpu_addr_i  = ca;
    cpu_wdata_i = cd;
    dma_req_i   = dr;
    dma_we_i    = dw;
    dma_addr_i  = da;
    dma_wdata_i = dd;
    mem_rdata_i = md;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic        exp_dma;
    logic [31:0] exp_addr;
    int          phase;

    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_mem_read", 32'(mem_read_o), 0);
    checkOutput("rst_mem_write", 32'(mem_write_o), 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata_o, 0);
    checkOutput("rst_dma_rdata", dma_rdata_o, 0);
    checkOutput("rst_dma_gnt", 32'(dma_gnt_o), 0);
    checkOutput("rst_dma_rvalid", 32'(dma_rvalid_o), 0);
    checkOutput("rst_stall_idle", 32'(cpu_stall_o), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_stall_req", 32'(cpu_stall_o), 1);

    $display("[TB] CPU read of 0x10");
    rst_i = 1'b0;
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    checkOutput("rd_stall_c0", 32'(cpu_stall_o), 1);
    tick();
    checkOutput("rd_read_c1", 32'(mem_read_o), 1);
    checkOutput("rd_write_c1", 32'(mem_write_o), 0);
    checkOutput("rd_addr_c1", mem_addr_o, 32'h10);
    checkOutput("rd_stall_c1", 32'(cpu_stall_o), 1);
    tick();
    checkOutput("rd_read_c2", 32'(mem_read_o), 1);
    checkOutput("rd_addr_c2", mem_addr_o, 32'h10);
    checkOutput("rd_stall_c2", 32'(cpu_stall_o), 1);
    tick();
    checkOutput("rd_read_resp", 32'(mem_read_o), 0);
    checkOutput("rd_stall_resp", 32'(cpu_stall_o), 0);
    checkOutput("rd_rdata", cpu_rdata_o, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    tick();
    checkOutput("rd_read_idle", 32'(mem_read_o), 0);

    $display("[TB] CPU write of 0x20");
    applyStimulus(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 32'hBAD0BAD0);
    tick();
    checkOutput("wr_write_c1", 32'(mem_write_o), 1);
    checkOutput("wr_read_c1", 32'(mem_read_o), 0);
    checkOutput("wr_addr_c1", mem_addr_o, 32'h20);
    checkOutput("wr_wdata_c1", mem_wdata_o, 32'h12345678);
    tick();
    checkOutput("wr_write_c2", 32'(mem_write_o), 1);
    checkOutput("wr_addr_c2", mem_addr_o, 32'h20);
    checkOutput("wr_wdata_c2", mem_wdata_o, 32'h12345678);
    tick();
    checkOutput("wr_write_resp", 32'(mem_write_o), 0);
    checkOutput("wr_read_resp", 32'(mem_read_o), 0);
    checkOutput("wr_stall_resp", 32'(cpu_stall_o), 0);
    checkOutput("wr_rdata_kept", cpu_rdata_o, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] simultaneous requests held from reset");
    rst_i = 1'b1;
    applyStimulus(1, 0, 32'h30, 0, 1, 0, 32'h50, 0, 32'h11112222);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    checkOutput("tie_cpu_read", 32'(mem_read_o), 1);
    checkOutput("tie_cpu_addr", mem_addr_o, 32'h30);
    checkOutput("tie_cpu_nognt", 32'(dma_gnt_o), 0);
    tick();
    tick();
    checkOutput("tie_cpu_rdata", cpu_rdata_o, 32'h11112222);
    checkOutput("tie_cpu_stall", 32'(cpu_stall_o), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h50, 0, 32'h33334444);
    tick();
    checkOutput("tie_idle_nognt", 32'(dma_gnt_o), 0);
    checkOutput("tie_idle_read", 32'(mem_read_o), 0);
    tick();
    checkOutput("tie_dma_gnt", 32'(dma_gnt_o), 1);
    checkOutput("tie_dma_addr", mem_addr_o, 32'h50);
    checkOutput("tie_dma_read", 32'(mem_read_o), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h33334444);
    tick();
    checkOutput("tie_gnt_pulse", 32'(dma_gnt_o), 0);
    checkOutput("tie_rvalid_early", 32'(dma_rvalid_o), 0);
    tick();
    checkOutput("tie_rvalid", 32'(dma_rvalid_o), 1);
    checkOutput("tie_dma_rdata", dma_rdata_o, 32'h33334444);
    tick();
    checkOutput("tie_rvalid_pulse", 32'(dma_rvalid_o), 0);

    $display("[TB] both requests held for four accesses");
    applyStimulus(1, 0, 32'h60, 0, 1, 0, 32'h70, 0, 32'h5555AAAA);
    for (int k = 0; k < 16; k++) begin
      tick();
      phase    = k % 4;
      exp_dma  = ((k / 4) % 2) == 1;
      exp_addr = exp_dma ? 32'h70 : 32'h60;
      checkOutput($sformatf("rr_read_%0d", k), 32'(mem_read_o), (phase < 2) ? 1 : 0);
      checkOutput($sformatf("rr_gnt_%0d", k), 32'(dma_gnt_o),
                  (phase == 0 && exp_dma) ? 1 : 0);
      checkOutput($sformatf("rr_rvalid_%0d", k), 32'(dma_rvalid_o),
                  (phase == 2 && exp_dma) ? 1 : 0);
      if (phase < 2) begin
        checkOutput($sformatf("rr_addr_%0d", k), mem_addr_o, exp_addr);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] DMA read of 0x40 with address changed after grant");
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 0, 32'hCAFEF00D);
    tick();
    checkOutput("dma_gnt", 32'(dma_gnt_o), 1);
    checkOutput("dma_addr_c1", mem_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFF, 32'h99, 32'hCAFEF00D);
    tick();
    checkOutput("dma_addr_c2", mem_addr_o, 32'h40);
    checkOutput("dma_read_c2", 32'(mem_read_o), 1);
    checkOutput("dma_write_c2", 32'(mem_write_o), 0);
    tick();
    checkOutput("dma_rvalid", 32'(dma_rvalid_o), 1);
    checkOutput("dma_rdata", dma_rdata_o, 32'hCAFEF00D);
    tick();

    $display("[TB] reset in the middle of a CPU write");
    applyStimulus(1, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    tick();
    checkOutput("abort_write_c1", 32'(mem_write_o), 1);
    tick();
    checkOutput("abort_write_c2", 32'(mem_write_o), 1);
    rst_i = 1'b1;
    applyStimulus(1, 0, 32'h90, 0, 1, 0, 32'h44, 0, 32'h0);
    tick();
    checkOutput("abort_write_off", 32'(mem_write_o), 0);
    checkOutput("abort_read_off", 32'(mem_read_o), 0);
    checkOutput("abort_addr_clr", mem_addr_o, 0);
    checkOutput("abort_stall_rst", 32'(cpu_stall_o), 1);
    rst_i = 1'b0;
    tick();
    checkOutput("abort_tie_cpu_read", 32'(mem_read_o), 1);
    checkOutput("abort_tie_cpu_addr", mem_addr_o, 32'h90);
    checkOutput("abort_tie_nognt", 32'(dma_gnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
